// File: rtl/shift_out_ser_pkg.sv
// Shared types and helpers for the parallel-in/serial-out shifter.
package shift_out_ser_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ser_state_e;

  // Registered serial-side outputs, kept together so they load and hold as a unit.
  typedef struct packed {
    logic sout;
    logic sout_valid;
    logic bit_start;
    logic done;
  } ser_out_t;

  function automatic int ser_clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/shift_out_ser_if.sv
// Word handshake, control and serial output bundle of the shifter.
interface shift_out_if #(
  parameter int WIDTH = 64
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             enable;
  logic             abort;
  logic             sout;
  logic             sout_valid;
  logic             bit_start;
  logic             done;

  modport master (
    output in_data, in_valid, enable, abort,
    input  in_ready, sout, sout_valid, bit_start, done
  );

  modport slave (
    input  in_data, in_valid, enable, abort,
    output in_ready, sout, sout_valid, bit_start, done
  );
endinterface

// File: rtl/shift_out_ser_bitclk.sv
// Bit-period divider: counts enabled clocks and ticks on the last clock of each bit.
module shift_out_bitclk
  import shift_out_ser_pkg::*;
#(
  parameter int DIV    = 1,
  parameter int DWIDTH = ser_clog2(DIV + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  generate
    if (DIV == 1) begin : g_div1
      // Every enabled clock ends a bit; no counter state exists.
      logic unused_ok;
      assign unused_ok = &{1'b0, clk, reset, clr};
      assign tick      = en;
    end else begin : g_divn
      localparam logic [DWIDTH-1:0] LAST = DWIDTH'(DIV - 1);
      logic [DWIDTH-1:0] cnt;

      always_ff @(posedge clk) begin
        if (reset || clr)  cnt <= '0;
        else if (en)       cnt <= (cnt == LAST) ? '0 : cnt + DWIDTH'(1);
      end

      assign tick = en && (cnt == LAST);
    end
  endgenerate

endmodule

// File: rtl/shift_out_ser.sv
// Parallel-in/serial-out shifter: takes a word on valid/ready and emits it
// bit by bit on a registered sout, DIV clocks per bit, with pause and abort.
module shift_out_ser
  import shift_out_ser_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int CWIDTH     = ser_clog2(WIDTH),
  parameter int MSB_FIRST  = 0,
  parameter int DIV        = 1,
  parameter int DWIDTH     = ser_clog2(DIV + 1),
  parameter bit IDLE_LEVEL = 1'b0
) (
  input logic        clk,
  input logic        reset,
  shift_out_if.slave bus
);

  localparam ser_out_t OUT_IDLE = '{sout: IDLE_LEVEL, sout_valid: 1'b0,
                                    bit_start: 1'b0, done: 1'b0};

  ser_state_e        state, state_nxt;
  logic [WIDTH-1:0]  data_q, data_nxt;
  logic [CWIDTH-1:0] idx_q, idx_nxt;
  ser_out_t          out_q, out_nxt;

  logic shifting, abort_sh, last, tick, rdy, accept;

  function automatic logic sel_bit(input logic [WIDTH-1:0] d, input logic [CWIDTH-1:0] i);
    logic [CWIDTH-1:0] ri;
    ri = CWIDTH'(WIDTH - 1) - i;
    return (MSB_FIRST != 0) ? d[ri] : d[i];
  endfunction

  assign shifting = (state == ST_SHIFT);
  assign abort_sh = shifting && bus.abort;
  assign last     = (idx_q == CWIDTH'(WIDTH - 1));

  shift_out_bitclk #(.DIV(DIV), .DWIDTH(DWIDTH)) u_bitclk (
    .clk   (clk),
    .reset (reset),
    .en    (shifting && bus.enable),
    .clr   (!shifting || abort_sh),
    .tick  (tick)
  );

  // Ready on the final clock of the last bit lets the next word follow with no gap;
  // a concurrent abort still wins over that accept.
  assign rdy    = !reset && ((state == ST_IDLE) || (shifting && tick && last));
  assign accept = bus.in_valid && rdy;

  always_comb begin
    state_nxt         = state;
    data_nxt          = data_q;
    idx_nxt           = idx_q;
    out_nxt           = out_q;
    out_nxt.bit_start = 1'b0;
    out_nxt.done      = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt          = ST_SHIFT;
          data_nxt           = bus.in_data;
          idx_nxt            = '0;
          out_nxt.sout       = sel_bit(bus.in_data, '0);
          out_nxt.sout_valid = 1'b1;
          out_nxt.bit_start  = 1'b1;
        end else begin
          out_nxt = OUT_IDLE;
        end
      end
      ST_SHIFT: begin
        if (bus.abort) begin
          state_nxt = ST_IDLE;
          idx_nxt   = '0;
          out_nxt   = OUT_IDLE;
        end else if (tick) begin
          if (last) begin
            if (accept) begin
              data_nxt           = bus.in_data;
              idx_nxt            = '0;
              out_nxt.sout       = sel_bit(bus.in_data, '0);
              out_nxt.sout_valid = 1'b1;
              out_nxt.bit_start  = 1'b1;
            end else begin
              state_nxt = ST_IDLE;
              idx_nxt   = '0;
              out_nxt   = OUT_IDLE;
            end
            out_nxt.done = 1'b1;
          end else begin
            idx_nxt           = idx_q + CWIDTH'(1);
            out_nxt.sout      = sel_bit(data_q, idx_q + CWIDTH'(1));
            out_nxt.bit_start = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        out_nxt   = OUT_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      data_q <= '0;
      idx_q  <= '0;
      out_q  <= OUT_IDLE;
    end else begin
      state  <= state_nxt;
      data_q <= data_nxt;
      idx_q  <= idx_nxt;
      out_q  <= out_nxt;
    end
  end

  assign bus.in_ready   = rdy;
  assign bus.sout       = out_q.sout;
  assign bus.sout_valid = out_q.sout_valid;
  assign bus.bit_start  = out_q.bit_start;
  assign bus.done       = out_q.done;

endmodule

// File: tb/tb_shift_out_ser.sv
// Bench for shift_out_ser: three configurations driven by shared stimulus,
// each checked every clock against a word/time-based reference model.
module tb_shift_out_ser;
  localparam int W  = 8;
  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset    = 1'b1;
  logic [W-1:0] in_data  = '0;
  logic         in_valid = 1'b0;
  logic         enable   = 1'b1;
  logic         abort    = 1'b0;

  shift_out_if #(.WIDTH(W)) if0 ();
  shift_out_if #(.WIDTH(W)) if1 ();
  shift_out_if #(.WIDTH(W)) if2 ();

  assign if0.in_data = in_data;  assign if0.in_valid = in_valid;
  assign if0.enable  = enable;   assign if0.abort    = abort;
  assign if1.in_data = in_data;  assign if1.in_valid = in_valid;
  assign if1.enable  = enable;   assign if1.abort    = abort;
  assign if2.in_data = in_data;  assign if2.in_valid = in_valid;
  assign if2.enable  = enable;   assign if2.abort    = abort;

  shift_out_ser #(.WIDTH(W), .MSB_FIRST(1), .DIV(1), .IDLE_LEVEL(1'b0))
    u0 (.clk(clk), .reset(reset), .bus(if0.slave));
  shift_out_ser #(.WIDTH(W), .MSB_FIRST(0), .DIV(1), .IDLE_LEVEL(1'b1))
    u1 (.clk(clk), .reset(reset), .bus(if1.slave));
  shift_out_ser #(.WIDTH(W), .MSB_FIRST(1), .DIV(3), .IDLE_LEVEL(1'b0))
    u2 (.clk(clk), .reset(reset), .bus(if2.slave));

  logic [NI-1:0] o_sout, o_sv, o_bs, o_done, o_rdy;
  assign o_sout = {if2.sout,       if1.sout,       if0.sout};
  assign o_sv   = {if2.sout_valid, if1.sout_valid, if0.sout_valid};
  assign o_bs   = {if2.bit_start,  if1.bit_start,  if0.bit_start};
  assign o_done = {if2.done,       if1.done,       if0.done};
  assign o_rdy  = {if2.in_ready,   if1.in_ready,   if0.in_ready};

  function automatic int  mdiv (input int k); return (k == 2) ? 3 : 1; endfunction
  function automatic bit  mmsb (input int k); return (k != 1);        endfunction
  function automatic logic midle(input int k); return (k == 1);       endfunction

  // Model: a busy word plus the count t of enabled clocks spent on it;
  // the current bit is t/DIV and a bit starts whenever t%DIV == 0.
  logic         m_busy [NI];
  logic [W-1:0] m_word [NI];
  int           m_t    [NI];
  logic         e_sout [NI];
  logic         e_sv   [NI];
  logic         e_bs   [NI];
  logic         e_done [NI];

  int n_asrt = 0;
  int n_fail = 0;
  int dcnt [NI];

  function automatic logic bit_of(input int k, input logic [W-1:0] w, input int i);
    return mmsb(k) ? w[W-1-i] : w[i];
  endfunction

  function automatic logic m_ready(input int k);
    return !reset && (!m_busy[k] || (enable && m_t[k] == W*mdiv(k) - 1));
  endfunction

  task automatic m_idle(input int k);
    m_busy[k] = 1'b0; e_sout[k] = midle(k); e_sv[k] = 1'b0;
  endtask

  task automatic m_start(input int k);
    m_busy[k] = 1'b1; m_word[k] = in_data; m_t[k] = 0;
    e_sout[k] = bit_of(k, in_data, 0); e_sv[k] = 1'b1; e_bs[k] = 1'b1;
  endtask

  task automatic model_edge();
    for (int k = 0; k < NI; k++) begin
      e_bs[k] = 1'b0; e_done[k] = 1'b0;
      if (reset) m_idle(k);
      else if (m_busy[k] && abort) m_idle(k);
      else if (m_busy[k] && !enable) ;
      else if (m_busy[k]) begin
        if (m_t[k] == W*mdiv(k) - 1) begin
          e_done[k] = 1'b1;
          if (in_valid) m_start(k);
          else          m_idle(k);
        end else begin
          m_t[k]++;
          e_sout[k] = bit_of(k, m_word[k], m_t[k] / mdiv(k));
          e_bs[k]   = (m_t[k] % mdiv(k)) == 0;
        end
      end else if (in_valid) m_start(k);
    end
  endtask

  task automatic chk(input string tag, input int k, input logic obs, input logic exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[%0d] observed=%b expected=%b t=%0t", tag, k, obs, exp, $time);
    end
  endtask

  task automatic chk_int(input string tag, input int k, input int obs, input int exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[%0d] observed=%0d expected=%0d", tag, k, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk("in_ready",   k, o_rdy[k],  m_ready(k));
      chk("sout",       k, o_sout[k], e_sout[k]);
      chk("sout_valid", k, o_sv[k],   e_sv[k]);
      chk("bit_start",  k, o_bs[k],   e_bs[k]);
      chk("done",       k, o_done[k], e_done[k]);
      if (o_done[k] === 1'b1) dcnt[k]++;
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic send(input logic [W-1:0] d);
    in_valid = 1'b1; in_data = d;
    cyc();
    in_valid = 1'b0; in_data = W'($urandom);
  endtask

  task automatic clr_dcnt();
    for (int k = 0; k < NI; k++) dcnt[k] = 0;
  endtask

  task automatic chk_dcnt(input string tag, input int e0, input int e1, input int e2);
    chk_int(tag, 0, dcnt[0], e0);
    chk_int(tag, 1, dcnt[1], e1);
    chk_int(tag, 2, dcnt[2], e2);
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      m_busy[k] = 1'b0; m_word[k] = '0; m_t[k] = 0; dcnt[k] = 0;
      e_sout[k] = midle(k); e_sv[k] = 1'b0; e_bs[k] = 1'b0; e_done[k] = 1'b0;
    end
    @(posedge clk);
    model_edge();
    #1;
    repeat (2) cyc();
    reset = 1'b0;
    repeat (2) cyc();

    clr_dcnt();
    send(8'hA5); repeat (30) cyc();
    chk_dcnt("done_a5", 1, 1, 1);

    clr_dcnt();
    send(8'h01); repeat (30) cyc();
    send(8'h80); repeat (30) cyc();
    chk_dcnt("done_01_80", 2, 2, 2);

    // Back-to-back: the narrow configurations take 8'h00 right after 8'hFF.
    clr_dcnt();
    in_valid = 1'b1; in_data = 8'hFF;
    cyc();
    in_data = 8'h00;
    repeat (8) cyc();
    in_valid = 1'b0;
    repeat (30) cyc();
    chk_dcnt("done_b2b", 2, 2, 1);

    // Pause in bit 3, then abort mid-word: no done may follow.
    clr_dcnt();
    send(8'hC3);
    repeat (3) cyc();
    enable = 1'b0; repeat (5) cyc();
    enable = 1'b1; repeat (3) cyc();
    abort = 1'b1; cyc();
    abort = 1'b0; repeat (3) cyc();
    chk_dcnt("done_abort", 0, 0, 0);

    // Abort while idle must not block an accept.
    abort = 1'b1; send(8'h5A); abort = 1'b0;
    repeat (30) cyc();
    chk_dcnt("done_idle_abort", 1, 1, 1);

    // Reset mid-word discards the word.
    clr_dcnt();
    send(8'h96);
    repeat (4) cyc();
    reset = 1'b1; repeat (3) cyc();
    reset = 1'b0; repeat (30) cyc();
    chk_dcnt("done_reset", 0, 0, 0);

    repeat (800) begin
      in_valid = 1'($urandom_range(1, 0));
      in_data  = W'($urandom);
      enable   = ($urandom_range(7, 0) != 0);
      abort    = ($urandom_range(31, 0) == 0);
      reset    = ($urandom_range(99, 0) == 0);
      cyc();
    end
    in_valid = 1'b0; enable = 1'b1; abort = 1'b0; reset = 1'b0;
    repeat (30) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
